// File: rtl/priority_encoder8to3.sv
// priority_encoder8to3: sequential 8-to-3 priority encoder with a valid/ready handshake.
// Requests accumulate in a sticky pending register. The highest-priority
// unmasked pending bit is granted and its code is held until it is accepted.
// Optional build macro PRIORITY_ENCODER_ROUND_ROBIN_EN:
//   defined   -> round-robin selection that starts after the last granted code
//   undefined -> fixed priority (bit 0 highest)
module priority_encoder8to3 #(
  parameter int NREQ   = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   mask,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [NREQ-1:0]   pending,
  output logic              any_pending
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_p0, state_d;
  logic [CODE_W-1:0]   code_p0, code_d;
  logic [NREQ-1:0]     pending_p0, pending_d;
  logic [NREQ-1:0]     elig;
  logic [NREQ-1:0]     clr;
  logic                accept;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [CODE_W-1:0]   ptr_p0;

  // Search starts one past the last granted code and wraps modulo NREQ.
  function automatic logic [CODE_W-1:0] select_code(input logic [NREQ-1:0] e,
                                                    input logic [CODE_W-1:0] last);
    logic [CODE_W-1:0] sel;
    logic [CODE_W-1:0] idx;
    logic              found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = last + CODE_W'(i) + CODE_W'(1);
      if (!found && e[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction
`else
  // Fixed priority: the lowest set index wins.
  function automatic logic [CODE_W-1:0] select_code(input logic [NREQ-1:0] e);
    logic [CODE_W-1:0] sel;
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (e[i]) sel = CODE_W'(i);
    end
    return sel;
  endfunction
`endif

  assign elig        = pending_p0 & ~mask;
  assign accept      = (state_p0 == HOLD) && ready;
  assign clr         = accept ? (NREQ'(1) << code_p0) : '0;
  assign code        = code_p0;
  assign valid       = (state_p0 == HOLD);
  assign pending     = pending_p0;
  assign any_pending = |pending_p0;

  // Next state, next code and pending update; a new request on the accepted bit keeps it set.
  always_comb begin
    state_d   = state_p0;
    code_d    = code_p0;
    pending_d = (pending_p0 & ~clr) | req;
    case (state_p0)
      IDLE: begin
        if (elig != '0) begin
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
          code_d  = select_code(elig, ptr_p0);
`else
          code_d  = select_code(elig);
`endif
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: state, code and pending registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= IDLE;
      code_p0    <= '0;
      pending_p0 <= '0;
    end else begin
      state_p0   <= state_d;
      code_p0    <= code_d;
      pending_p0 <= pending_d;
    end
  end

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  // Remember the last accepted code; reset value makes the first search start at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0 <= CODE_W'(NREQ - 1);
    end else if (accept) begin
      ptr_p0 <= code_p0;
    end
  end
`endif

endmodule
